// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with manual modes and an automatic burst-shift sequencer
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             sdi_lsb,
  input  logic             sdi_msb,
  input  logic [WIDTH-1:0] pdi,
  input  logic             start,
  input  logic             burst_dir,
  input  logic [CW-1:0]    burst_len,
  output logic [WIDTH-1:0] pdo,
  output logic             sdo_msb,
  output logic             sdo_lsb,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [CW-1:0] WMAX = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt, shl, shr, man;
  logic [CW-1:0] count, count_nxt, len_sat;
  logic dir, dir_nxt, done_nxt, accept;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = (start && len_sat != '0) ? BURST : IDLE;
    else state_nxt = (count <= ONE) ? IDLE : BURST;
  end
  always_comb busy = state == BURST;
  // start in IDLE freezes q for that cycle and latches the burst parameters
  assign accept  = state == IDLE && start;
  assign len_sat = burst_len > WMAX ? WMAX : burst_len;
  assign shl     = {q[WIDTH-2:0], sdi_lsb};
  assign shr     = {sdi_msb, q[WIDTH-1:1]};
  assign man     = mode == 2'b01 ? shl : mode == 2'b10 ? shr : mode == 2'b11 ? pdi : q;
  always_comb begin
    q_nxt     = busy ? (dir ? shr : shl) : accept ? q : man;
    count_nxt = busy ? count - ONE : accept ? len_sat : count;
    dir_nxt   = accept ? burst_dir : dir;
    done_nxt  = busy ? count == ONE : accept && len_sat == '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q     <= '0;
      count <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      q     <= q_nxt;
      count <= count_nxt;
      dir   <= dir_nxt;
      done  <= done_nxt;
    end
  assign pdo     = q;
  assign sdo_msb = q[WIDTH-1];
  assign sdo_lsb = q[0];
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed scoreboard bench for shift_reg_univ at WIDTH=8
module tb_shift_reg_univ;
  localparam int WIDTH = 8;
  localparam int CW = $clog2(WIDTH+1);
  logic clk = 1'b0;
  logic reset_n, sdi_lsb, sdi_msb, start, burst_dir, sdo_msb, sdo_lsb, busy, done;
  logic [1:0] mode;
  logic [WIDTH-1:0] pdi, pdo;
  logic [CW-1:0] burst_len;
  typedef struct {string tag; logic [9:0] exp;} exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sdi_lsb(sdi_lsb), .sdi_msb(sdi_msb),
    .pdi(pdi), .start(start), .burst_dir(burst_dir), .burst_len(burst_len),
    .pdo(pdo), .sdo_msb(sdo_msb), .sdo_lsb(sdo_lsb), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input string tag, input logic [9:0] exp);
    sb.push_back('{tag, exp});
  endtask
  task automatic pop_chk(input logic [9:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty obs=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.exp);
      end
    end
  endtask
  task automatic step(input string tag, input logic [9:0] exp);
    push_exp(tag, exp);
    tick();
    pop_chk({busy, done, pdo});
  endtask
  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    push_exp(tag, {9'b0, exp});
    pop_chk({9'b0, obs});
  endtask
  initial begin
    int n;
    logic [11:0] pat;
    reset_n = 1'b0; mode = 2'b00; sdi_lsb = 1'b0; sdi_msb = 1'b0; pdi = '0;
    start = 1'b0; burst_dir = 1'b0; burst_len = '0;
    #3;
    push_exp("reset_init", {2'b00, 8'h00});
    pop_chk({busy, done, pdo});
    #1 reset_n = 1'b1;
    mode = 2'b11; pdi = 8'hFF;
    step("load_ff", {2'b00, 8'hFF});
    #2 reset_n = 1'b0;
    #1;
    push_exp("async_reset", {2'b00, 8'h00});
    pop_chk({busy, done, pdo});
    #1 reset_n = 1'b1;
    pdi = 8'hA5; mode = 2'b11;
    step("load_a5", {2'b00, 8'hA5});
    chk_bit("sdo_lsb_a5", sdo_lsb, 1'b1);
    mode = 2'b01; sdi_lsb = 1'b1;
    step("shl_4b", {2'b00, 8'h4B});
    mode = 2'b11;
    step("reload_a5", {2'b00, 8'hA5});
    mode = 2'b10; sdi_msb = 1'b0;
    step("shr_52", {2'b00, 8'h52});
    chk_bit("sdo_lsb_52", sdo_lsb, 1'b0);
    mode = 2'b00;
    step("hold_52", {2'b00, 8'h52});
    mode = 2'b11; pdi = 8'h81;
    step("load_81", {2'b00, 8'h81});
    mode = 2'b00; start = 1'b1; burst_dir = 1'b0; burst_len = 4'd3; sdi_lsb = 1'b0;
    step("burst_start", {2'b10, 8'h81});
    start = 1'b0; mode = 2'b11; pdi = 8'hFF;
    step("burst_s1", {2'b10, 8'h02});
    chk_bit("burst_msb1", sdo_msb, 1'b0);
    mode = 2'b10;
    step("burst_s2", {2'b10, 8'h04});
    chk_bit("burst_msb2", sdo_msb, 1'b0);
    mode = 2'b01;
    step("burst_s3_done", {2'b01, 8'h08});
    chk_bit("burst_msb3", sdo_msb, 1'b0);
    mode = 2'b00;
    step("burst_after", {2'b00, 8'h08});
    start = 1'b1; burst_len = 4'd0;
    step("len0_done", {2'b01, 8'h08});
    start = 1'b0;
    step("len0_after", {2'b00, 8'h08});
    mode = 2'b11; pdi = 8'hFF;
    step("load_ff2", {2'b00, 8'hFF});
    mode = 2'b00; start = 1'b1; burst_dir = 1'b1; burst_len = 4'd15; sdi_msb = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      start = (n == 2);
      if (n == 3) begin
        mode = 2'b11; pdi = 8'hAA;
      end
      tick();
    end
    start = 1'b0; mode = 2'b00;
    push_exp("sat_busy_cycles", 10'd8);
    pop_chk(10'(n));
    push_exp("sat_done", {2'b01, 8'h00});
    pop_chk({busy, done, pdo});
    step("busy_start_ignored", {2'b00, 8'h00});
    mode = 2'b11; pdi = 8'h0F;
    step("load_0f", {2'b00, 8'h0F});
    mode = 2'b00; start = 1'b1; burst_dir = 1'b0; burst_len = 4'd6; sdi_lsb = 1'b0;
    step("rb_start", {2'b10, 8'h0F});
    start = 1'b0;
    step("rb_s1", {2'b10, 8'h1E});
    step("rb_s2", {2'b10, 8'h3C});
    #2 reset_n = 1'b0;
    #1;
    push_exp("rb_reset", {2'b00, 8'h00});
    pop_chk({busy, done, pdo});
    #1 reset_n = 1'b1;
    step("rb_after1", {2'b00, 8'h00});
    step("rb_after2", {2'b00, 8'h00});
    pat = 12'b0000_0001_1001;
    mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      sdi_lsb = pat[i];
      if (i < 5) push_exp($sformatf("siso_%0d", i), {9'b0, pat[i]});
      tick();
      if (i >= 7) pop_chk({9'b0, sdo_msb});
    end
    mode = 2'b11; pdi = 8'h01;
    step("bb_load", {2'b00, 8'h01});
    mode = 2'b00; start = 1'b1; burst_dir = 1'b0; burst_len = 4'd2; sdi_lsb = 1'b0;
    step("bb1_start", {2'b10, 8'h01});
    start = 1'b0;
    step("bb1_s1", {2'b10, 8'h02});
    step("bb1_done", {2'b01, 8'h04});
    start = 1'b1; burst_dir = 1'b1; burst_len = 4'd2; sdi_msb = 1'b0;
    step("bb2_start", {2'b10, 8'h04});
    start = 1'b0;
    step("bb2_s1", {2'b10, 8'h02});
    step("bb2_done", {2'b01, 8'h01});
    step("bb2_after", {2'b00, 8'h01});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter CW, default $clog2(WIDTH+1), width of burst_len.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port mode  input  2  manual op: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-006 SHALL have port sdi_lsb  input  1  serial in, enters bit 0 on left shift.
REQ-007 SHALL have port sdi_msb  input  1  serial in, enters bit WIDTH-1 on right shift.
REQ-008 SHALL have port pdi  input  WIDTH  parallel load data.
REQ-009 SHALL have port start  input  1  one-cycle request to begin an automatic burst shift.
REQ-010 SHALL have port burst_dir  input  1  burst direction: 0 left, 1 right; sampled with start.
REQ-011 SHALL have port burst_len  input  CW  number of burst shifts; sampled with start.
REQ-012 SHALL have port pdo  output  WIDTH  register contents q.
REQ-013 SHALL have port sdo_msb  output  1  q[WIDTH-1], combinational from q.
REQ-014 SHALL have port sdo_lsb  output  1  q[0], combinational from q.
REQ-015 SHALL have port busy  output  1  high while a burst is in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-017 SHALL implement left shift as q <= {q[WIDTH-2:0], sdi_lsb}.
REQ-018 SHALL implement right shift as q <= {sdi_msb, q[WIDTH-1:1]}.
REQ-019 SHALL implement parallel load as q <= pdi, and hold as q unchanged.
REQ-020 SHALL run a two-state FSM, IDLE (busy=0) and BURST (busy=1).
REQ-021 In IDLE with start=0: SHALL apply mode each cycle.
REQ-022 In IDLE with start=1: SHALL ignore mode that cycle and leave q unchanged; SHALL latch burst_dir; SHALL load count = min(burst_len, WIDTH).
REQ-023 Start with loaded count >0: SHALL go to BURST (busy=1 from the next cycle).
REQ-024 Start with burst_len=0: SHALL stay in IDLE and assert done for the following cycle, with no shift.
REQ-025 In BURST: SHALL perform one shift per edge in the latched direction, using sdi_lsb/sdi_msb sampled at that edge, and decrement count.
REQ-026 In BURST: SHALL ignore mode and start entirely; start during busy SHALL NOT be queued.
REQ-027 On the edge where count decrements from 1 to 0: SHALL return to IDLE and assert done for exactly one cycle, coincident with busy=0.
REQ-028 A burst of N SHALL produce exactly N shifts, with busy high for exactly N cycles.
REQ-029 A start on the cycle done is high SHALL be accepted (back-to-back bursts).
REQ-030 burst_len > WIDTH SHALL saturate to WIDTH shifts.
REQ-031 With mode=01 held and WIDTH=N: sdo_msb SHALL equal sdi_lsb delayed by N cycles (SISO-compatible).

Reset
REQ-032 reset_n=0 SHALL immediately, independent of clk, force q=0, busy=0, done=0, count=0 and FSM=IDLE.
REQ-033 Reset during BURST SHALL abort the burst with no done pulse; after release, no pending shifts SHALL resume.
REQ-034 The first active edge after reset release SHALL obey REQ-021/REQ-022.

Verification (WIDTH=8)
REQ-035 Reset: assert reset_n=0 mid-cycle -> pdo=8'h00, busy=0, done=0 before the next clk edge.
REQ-036 Manual ops: load 8'hA5, then mode=01 with sdi_lsb=1 -> pdo=8'h4B; reload 8'hA5, then mode=10 with sdi_msb=0 -> pdo=8'h52.
REQ-037 Burst: load 8'h81; start, burst_dir=0, burst_len=3, sdi_lsb=0 -> busy high 3 cycles, sdo_msb sequence 0,0,0, final pdo=8'h08, done high 1 cycle; mode toggled during busy has no effect.
REQ-038 Edge cases:
  - burst_len=0 -> done next cycle, busy never high, pdo unchanged.
  - burst_len=15 -> exactly 8 shifts.
  - start during busy -> ignored.
REQ-039 Reset mid-burst: burst_len=6, reset_n low after 2 shifts -> pdo=8'h00, busy=0, no done; after release, pdo holds at 8'h00 with mode=00.
REQ-040 SISO check: mode=01, sdi_lsb pattern 1,0,0,1,1 -> same pattern on sdo_msb 8 cycles later; back-to-back bursts via start on the done cycle both complete.
